// File: rtl/pll_apb_reconfig_pkg.sv
// Shared types and constants for the PLL APB reconfiguration sequencer.
package pll_apb_reconfig_pkg;

    localparam int unsigned APB_AW    = 5;
    localparam int unsigned APB_DW    = 8;
    localparam int unsigned RATIO_W   = 8;
    localparam int unsigned RATIO_MIN = 1;
    localparam int unsigned RATIO_MAX = 128;

    localparam logic [APB_AW-1:0] ADDR_RATIOI_DEF = 5'h00;
    localparam logic [APB_AW-1:0] ADDR_RATIO0_DEF = 5'h01;
    localparam logic [APB_AW-1:0] ADDR_RATIO1_DEF = 5'h02;
    localparam logic [APB_AW-1:0] ADDR_RATIOF_DEF = 5'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_ASSERT,
        S_SETUP,
        S_ACCESS,
        S_RST_RELEASE,
        S_WAIT_LOCK,
        S_DONE,
        S_TMO
    } state_e;

    function automatic logic ratio_legal(input logic [RATIO_W-1:0] r);
        return (r >= RATIO_W'(RATIO_MIN)) && (r <= RATIO_W'(RATIO_MAX));
    endfunction

endpackage

// File: rtl/pll_apb_reconfig_lock_filter.sv
// Synchronizes the asynchronous PLL lock and flags when it has stayed high
// for LOCK_STABLE consecutive synchronized cycles.
module pll_lock_filter #(
    parameter int unsigned LOCK_STABLE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_i,
    input  logic clear_i,
    output logic lock_stable_o
);

    localparam int unsigned CW = $clog2(LOCK_STABLE) + 1;

    logic          sync1_q;
    logic          lock_s_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;

    // Counter saturates at LOCK_STABLE; any low sample restarts the run.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !lock_s_q) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(LOCK_STABLE)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // stable_q anticipates the next cycle so the flag lines up with lock_s_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= lock_i;
            lock_s_q <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= sync1_q && (cnt_d >= CW'(LOCK_STABLE - 1));
        end
    end

    assign lock_stable_o = stable_q;

endmodule

// File: rtl/pll_apb_reconfig.sv
// APB initiator that resets the PLL, writes four divider registers and waits
// for a stable lock, reporting done / cfg_err / timeout as single-cycle pulses.
module pll_apb_reconfig
    import pll_apb_reconfig_pkg::*;
#(
    parameter logic [APB_AW-1:0] ADDR_RATIOI  = ADDR_RATIOI_DEF,
    parameter logic [APB_AW-1:0] ADDR_RATIO0  = ADDR_RATIO0_DEF,
    parameter logic [APB_AW-1:0] ADDR_RATIO1  = ADDR_RATIO1_DEF,
    parameter logic [APB_AW-1:0] ADDR_RATIOF  = ADDR_RATIOF_DEF,
    parameter int unsigned       RST_HOLD     = 4,
    parameter int unsigned       LOCK_STABLE  = 8,
    parameter int unsigned       LOCK_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [RATIO_W-1:0] cfg_ratioi,
    input  logic [RATIO_W-1:0] cfg_ratio0,
    input  logic [RATIO_W-1:0] cfg_ratio1,
    input  logic [RATIO_W-1:0] cfg_ratiof,
    output logic               apb_rst_n,
    output logic               apb_sel,
    output logic               apb_en,
    output logic               apb_write,
    output logic [APB_AW-1:0]  apb_addr,
    output logic [APB_DW-1:0]  apb_wdata,
    output logic               pll_rst,
    input  logic               pll_lock,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               timeout
);

    localparam int unsigned HW = $clog2(RST_HOLD) + 1;
    localparam int unsigned WW = $clog2(LOCK_TIMEOUT) + 1;

    state_e                  state_q, state_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic [1:0]              idx_q, idx_d;
    logic [3:0][APB_DW-1:0]  data_q, data_d;

    logic                    cfg_ready_q, cfg_ready_d;
    logic                    busy_q, busy_d;
    logic                    pll_rst_q, pll_rst_d;
    logic                    apb_sel_q, apb_sel_d;
    logic                    apb_en_q, apb_en_d;
    logic [APB_AW-1:0]       apb_addr_q, apb_addr_d;
    logic [APB_DW-1:0]       apb_wdata_q, apb_wdata_d;
    logic                    done_q, done_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    timeout_q, timeout_d;
    logic                    apb_rst_n_q;

    logic                    lock_clear;
    logic                    lock_stable;
    logic                    req_legal;

    assign req_legal = ratio_legal(cfg_ratioi) && ratio_legal(cfg_ratio0) &&
                       ratio_legal(cfg_ratio1) && ratio_legal(cfg_ratiof);

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk           (clk),
        .rst           (rst),
        .lock_i        (pll_lock),
        .clear_i       (lock_clear),
        .lock_stable_o (lock_stable)
    );

    // Next state, then outputs decoded from the next state so they register in step.
    always_comb begin
        state_d    = state_q;
        hold_d     = '0;
        wait_d     = '0;
        idx_d      = idx_q;
        data_d     = data_q;
        cfg_err_d  = 1'b0;
        lock_clear = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = 2'd0;
                if (cfg_valid) begin
                    if (req_legal) begin
                        data_d[0] = cfg_ratioi - APB_DW'(1);
                        data_d[1] = cfg_ratio0 - APB_DW'(1);
                        data_d[2] = cfg_ratio1 - APB_DW'(1);
                        data_d[3] = cfg_ratiof - APB_DW'(1);
                        state_d   = S_RST_ASSERT;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RST_ASSERT: begin
                if (hold_q == HW'(RST_HOLD - 1)) begin
                    state_d = S_SETUP;
                    idx_d   = 2'd0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (idx_q == 2'd3) begin
                    state_d = S_RST_RELEASE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_SETUP;
                end
            end
            S_RST_RELEASE: begin
                lock_clear = 1'b1;
                state_d    = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                wait_d = wait_q + WW'(1);
                if (lock_stable) begin
                    state_d = S_DONE;
                end else if (wait_q == WW'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_TMO;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_TMO:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cfg_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        pll_rst_d   = (state_d == S_RST_ASSERT) || (state_d == S_SETUP) ||
                      (state_d == S_ACCESS);
        apb_sel_d   = (state_d == S_SETUP) || (state_d == S_ACCESS);
        apb_en_d    = (state_d == S_ACCESS);
        done_d      = (state_d == S_DONE);
        timeout_d   = (state_d == S_TMO);
        apb_addr_d  = '0;
        apb_wdata_d = '0;
        if (apb_sel_d) begin
            apb_wdata_d = data_d[idx_d];
            case (idx_d)
                2'd0:    apb_addr_d = ADDR_RATIOI;
                2'd1:    apb_addr_d = ADDR_RATIO0;
                2'd2:    apb_addr_d = ADDR_RATIO1;
                default: apb_addr_d = ADDR_RATIOF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            wait_q      <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            pll_rst_q   <= 1'b0;
            apb_sel_q   <= 1'b0;
            apb_en_q    <= 1'b0;
            apb_addr_q  <= '0;
            apb_wdata_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            wait_q      <= wait_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            pll_rst_q   <= pll_rst_d;
            apb_sel_q   <= apb_sel_d;
            apb_en_q    <= apb_en_d;
            apb_addr_q  <= apb_addr_d;
            apb_wdata_q <= apb_wdata_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // APB reset follows system reset, released one clock after rst falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_rst_n_q <= 1'b0;
        end else begin
            apb_rst_n_q <= 1'b1;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign pll_rst   = pll_rst_q;
    assign apb_sel   = apb_sel_q;
    assign apb_en    = apb_en_q;
    assign apb_write = apb_sel_q;
    assign apb_addr  = apb_addr_q;
    assign apb_wdata = apb_wdata_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign timeout   = timeout_q;
    assign apb_rst_n = apb_rst_n_q;

endmodule
